// File: rtl/booth_r4_mult.sv
// Radix-4 Booth multiplier with internal control FSM and Request/Done handshake.
// Optional macro BOOTH_UNSIGNED_EN adds a Signed port selecting zero/sign extension.
module booth_r4_mult #(
  parameter int N_LEN = 8
) (
  input  logic               Clock,
  input  logic               nReset,
  input  logic               Request,
  input  logic               Clear,
  input  logic [N_LEN-1:0]   op1,
  input  logic [N_LEN-1:0]   op2,
`ifdef BOOTH_UNSIGNED_EN
  input  logic               Signed,
`endif
  output logic               Ready,
  output logic               Done,
  output logic [2*N_LEN-1:0] Result
);

  localparam int YW = N_LEN + 2;
  localparam int AW = N_LEN + 4;
  localparam int K  = N_LEN / 2 + 1;
  localparam int CW = $clog2(K + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [AW-1:0] acc;
  logic [AW-1:0] m_reg;
  logic [YW-1:0] y_reg;
  logic          y_m1;
  logic [CW-1:0] cnt;

  logic          sgn;
  logic [AW-1:0] ext_m;
  logic [YW-1:0] ext_y;
  logic [2:0]    dig;
  logic [AW-1:0] pp;
  logic [AW-1:0] sum;
  logic [AW-1:0] acc_nx;
  logic [YW-1:0] y_nx;
  logic          last;
  logic          accept;

`ifdef BOOTH_UNSIGNED_EN
  assign sgn = Signed;
`else
  assign sgn = 1'b1;
`endif

  assign ext_m = {{(AW-N_LEN){sgn & op1[N_LEN-1]}}, op1};
  assign ext_y = {{2{sgn & op2[N_LEN-1]}}, op2};

  assign dig = {y_reg[1:0], y_m1};

  always_comb begin
    pp = '0;
    unique case (dig)
      3'b001, 3'b010: pp = m_reg;
      3'b011:         pp = m_reg << 1;
      3'b100:         pp = -(m_reg << 1);
      3'b101, 3'b110: pp = -m_reg;
      default:        pp = '0;
    endcase
  end

  // add, then shift {acc, y, y[-1]} right arithmetically by two
  assign sum    = acc + pp;
  assign acc_nx = {{2{sum[AW-1]}}, sum[AW-1:2]};
  assign y_nx   = {sum[1:0], y_reg[YW-1:2]};

  assign last   = (cnt == CW'(1));
  assign accept = (state == S_IDLE) && Request && !Clear;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (Request) state_nx = S_RUN;
      S_RUN:   if (last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (Clear) state_nx = S_IDLE;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state <= S_IDLE;
      Ready <= 1'b1;
      Done  <= 1'b0;
    end else begin
      state <= state_nx;
      Ready <= (state_nx == S_IDLE);
      Done  <= (state_nx == S_DONE);
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      acc    <= '0;
      m_reg  <= '0;
      y_reg  <= '0;
      y_m1   <= 1'b0;
      cnt    <= '0;
      Result <= '0;
    end else if (accept) begin
      acc   <= '0;
      m_reg <= ext_m;
      y_reg <= ext_y;
      y_m1  <= 1'b0;
      cnt   <= CW'(K);
    end else if (state == S_RUN && !Clear) begin
      acc   <= acc_nx;
      y_reg <= y_nx;
      y_m1  <= y_reg[1];
      cnt   <= cnt - CW'(1);
      if (last) Result <= {acc_nx[N_LEN-3:0], y_nx};
    end
  end

endmodule

// File: tb/tb_booth_r4_mult.sv
// Randomized scoreboard bench for booth_r4_mult against an arithmetic reference.
// Honors BOOTH_UNSIGNED_EN when defined at build time.
module tb_booth_r4_mult;

  localparam int N = 8;
  localparam int K = N / 2 + 1;

  logic           Clock = 1'b0;
  logic           nReset = 1'b0;
  logic           Request = 1'b0;
  logic           Clear = 1'b0;
  logic [N-1:0]   op1 = '0;
  logic [N-1:0]   op2 = '0;
  logic           sgn = 1'b1;
  logic           Ready;
  logic           Done;
  logic [2*N-1:0] Result;

  booth_r4_mult #(.N_LEN(N)) dut (
    .Clock   (Clock),
    .nReset  (nReset),
    .Request (Request),
    .Clear   (Clear),
    .op1     (op1),
    .op2     (op2),
`ifdef BOOTH_UNSIGNED_EN
    .Signed  (sgn),
`endif
    .Ready   (Ready),
    .Done    (Done),
    .Result  (Result)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [2*N-1:0] prod;
    int             cyc;
  } exp_t;

  exp_t           sbq[$];
  int             busy = 0;
  int             cyc = 0;
  logic [2*N-1:0] lastr = '0;
  int             n_chk = 0;
  int             n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a,
                                             input logic [N-1:0] b,
                                             input logic s);
    longint sa, sb, p;
    logic use_s;
`ifdef BOOTH_UNSIGNED_EN
    use_s = s;
`else
    use_s = 1'b1 | s;
`endif
    sa = use_s ? longint'($signed(a)) : longint'(a);
    sb = use_s ? longint'($signed(b)) : longint'(b);
    p  = sa * sb;
    return p[2*N-1:0];
  endfunction

  // Behavioural handshake model: busy counts cycles until Ready returns
  always @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      busy = 0;
      sbq.delete();
      lastr = '0;
    end else begin
      cyc++;
      if (Clear) begin
        busy = 0;
        sbq.delete();
      end else if (busy == 0) begin
        if (Request) begin
          exp_t e;
          e.prod = ref_mul(op1, op2, sgn);
          e.cyc  = cyc;
          sbq.push_back(e);
          busy = K + 1;
        end
      end else begin
        busy--;
      end
    end
  end

  always @(negedge Clock) begin
    chk("ready", 64'(Ready), 64'(busy == 0));
    chk("done", 64'(Done), 64'(busy == 1));
    if (busy == 1) begin
      if (sbq.size() == 0) begin
        chk("scoreboard_empty", 64'(sbq.size()), 64'd1);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", 64'(Result), 64'(e.prod));
        chk("latency", 64'(cyc - e.cyc), 64'(K));
        lastr = e.prod;
      end
    end else begin
      chk("result_hold", 64'(Result), 64'(lastr));
    end
  end

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic s);
    @(negedge Clock);
    op1 = a; op2 = b; sgn = s; Request = 1'b1;
    @(negedge Clock);
    Request = 1'b0; op1 = N'($urandom); op2 = N'($urandom);
    @(negedge Clock);
    Request = 1'b1;
    @(negedge Clock);
    Request = 1'b0;
    repeat (K - 1) @(negedge Clock);
  endtask

  initial begin
    repeat (3) @(negedge Clock);
    nReset = 1'b1;

    do_op(8'd7, 8'hFD, 1'b1);
    do_op(8'h80, 8'h80, 1'b1);
    do_op(8'hFF, 8'hFF, 1'b1);
    do_op(8'hFF, 8'hFF, 1'b0);
    do_op(8'h7F, 8'h80, 1'b1);
    do_op(8'h00, 8'h5A, 1'b1);
    do_op(8'h7F, 8'h7F, 1'b0);

    // Request held high: back-to-back accepts
    @(negedge Clock);
    Request = 1'b1;
    repeat (5 * (K + 1)) begin
      op1 = N'($urandom); op2 = N'($urandom); sgn = 1'($urandom);
      @(negedge Clock);
    end
    Request = 1'b0;
    repeat (K + 2) @(negedge Clock);

    // Clear on the third RUN cycle
    op1 = 8'h33; op2 = 8'hC5; sgn = 1'b1; Request = 1'b1;
    @(negedge Clock);
    Request = 1'b0;
    repeat (2) @(negedge Clock);
    Clear = 1'b1;
    @(negedge Clock);
    Clear = 1'b0;
    do_op(8'h12, 8'hEE, 1'b1);

    // Asynchronous reset mid-RUN
    op1 = 8'h55; op2 = 8'h66; Request = 1'b1;
    @(negedge Clock);
    Request = 1'b0;
    @(negedge Clock);
    #2 nReset = 1'b0;
    #1;
    chk("rst_result", 64'(Result), 64'd0);
    chk("rst_ready", 64'(Ready), 64'd1);
    chk("rst_done", 64'(Done), 64'd0);
    @(negedge Clock);
    nReset = 1'b1;
    repeat (K + 2) @(negedge Clock);
    do_op(8'hA5, 8'h3C, 1'b1);

    // Random traffic with occasional aborts
    repeat (400) begin
      @(negedge Clock);
      Request = 1'($urandom_range(0, 1));
      Clear   = ($urandom_range(0, 31) == 0);
      op1     = N'($urandom);
      op2     = N'($urandom);
      sgn     = 1'($urandom);
    end
    @(negedge Clock);
    Request = 1'b0;
    Clear   = 1'b0;
    repeat (K + 3) @(negedge Clock);
    chk("drain", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
